// File: rtl/alu_seq_if.sv
// ALU request/response bundle: the requester drives start/op/a/b, the ALU
// returns busy/done plus the registered result and {Z,N,C,V} flags.
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;

  modport master (
    output start, op, a, b,
    input  busy, done, result, flags
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, flags
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: IDLE -> EXEC -> DONE for single-cycle ops, IDLE -> MUL ->
// DONE for the iterative shift-add multiplier. Flags are {Z,N,C,V}.
// Optional feature macro: ALU_MUL_EN builds the MUL state and multiplier;
// without it op=111 takes the EXEC path and yields result 0.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  alu_seq_if.slave   bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
`ifdef ALU_MUL_EN
  localparam logic [1:0] S_MUL  = 2'd2;
`endif
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_ORR = 3'b011;
  localparam logic [2:0] OP_EOR = 3'b100;
  localparam logic [2:0] OP_LSL = 3'b101;
  localparam logic [2:0] OP_LSR = 3'b110;
`ifdef ALU_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b111;
  localparam int         CNT_W  = $clog2(WIDTH + 1);
`endif

  logic [1:0]       state_reg;
  logic [2:0]       op_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] result_reg;
  logic [3:0]       flags_reg;
  logic             busy_reg;
  logic             done_reg;

`ifdef ALU_MUL_EN
  // Full-width accumulator, left-shifting multiplicand, right-shifting multiplier.
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [CNT_W-1:0]   mul_cnt_reg;
`endif

  logic [WIDTH-1:0] exec_result;
  logic             exec_c;
  logic             exec_v;
  logic             exec_z;

  // Single-cycle datapath working purely from the latched operands.
  always_comb begin
    logic [WIDTH:0] sum_w;
    logic [WIDTH:0] diff_w;
    logic [WIDTH:0] shl_w;
    logic [WIDTH:0] shr_w;
    logic [3:0]     sh;
    sh          = b_reg[3:0];
    sum_w       = {1'b0, a_reg} + {1'b0, b_reg};
    diff_w      = {1'b0, a_reg} - {1'b0, b_reg};
    // Extra bit catches the last bit shifted out; it stays 0 for a zero shift.
    shl_w       = {1'b0, a_reg} << sh;
    shr_w       = {a_reg, 1'b0} >> sh;
    exec_result = '0;
    exec_c      = 1'b0;
    exec_v      = 1'b0;
    case (op_reg)
      OP_ADD: begin
        exec_result = sum_w[WIDTH-1:0];
        exec_c      = sum_w[WIDTH];
        exec_v      = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                      (sum_w[WIDTH-1] != a_reg[WIDTH-1]);
      end
      OP_SUB: begin
        exec_result = diff_w[WIDTH-1:0];
        exec_c      = ~diff_w[WIDTH];
        exec_v      = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                      (diff_w[WIDTH-1] != a_reg[WIDTH-1]);
      end
      OP_AND: exec_result = a_reg & b_reg;
      OP_ORR: exec_result = a_reg | b_reg;
      OP_EOR: exec_result = a_reg ^ b_reg;
      OP_LSL: begin
        exec_result = shl_w[WIDTH-1:0];
        exec_c      = shl_w[WIDTH];
      end
      OP_LSR: begin
        exec_result = shr_w[WIDTH:1];
        exec_c      = shr_w[0];
      end
      default: begin
        // op=111 reaching EXEC (multiplier not built) yields zero.
        exec_result = '0;
      end
    endcase
    exec_z = (exec_result == '0);
  end

  // Control FSM, operand latching, multiplier iteration and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      op_reg      <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      result_reg  <= '0;
      flags_reg   <= 4'b0000;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
`ifdef ALU_MUL_EN
      acc_reg     <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      mul_cnt_reg <= '0;
`endif
    end else begin
      case (state_reg)
        S_IDLE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            op_reg   <= bus.op;
            a_reg    <= bus.a;
            b_reg    <= bus.b;
            busy_reg <= 1'b1;
`ifdef ALU_MUL_EN
            if (bus.op == OP_MUL) begin
              state_reg   <= S_MUL;
              acc_reg     <= '0;
              mcand_reg   <= {{WIDTH{1'b0}}, bus.a};
              mplier_reg  <= bus.b;
              mul_cnt_reg <= '0;
            end else begin
              state_reg <= S_EXEC;
            end
`else
            state_reg <= S_EXEC;
`endif
          end
        end
        S_EXEC: begin
          result_reg <= exec_result;
          flags_reg  <= {exec_z, exec_result[WIDTH-1], exec_c, exec_v};
          done_reg   <= 1'b1;
          state_reg  <= S_DONE;
        end
`ifdef ALU_MUL_EN
        S_MUL: begin
          // WIDTH iteration cycles, then one cycle to register the product.
          if (mul_cnt_reg == CNT_W'(WIDTH)) begin
            result_reg <= acc_reg[WIDTH-1:0];
            flags_reg  <= {(acc_reg[WIDTH-1:0] == '0), acc_reg[WIDTH-1],
                           (acc_reg[2*WIDTH-1:WIDTH] != '0), 1'b0};
            done_reg   <= 1'b1;
            state_reg  <= S_DONE;
          end else begin
            if (mplier_reg[0]) begin
              acc_reg <= acc_reg + mcand_reg;
            end
            mcand_reg   <= mcand_reg << 1;
            mplier_reg  <= mplier_reg >> 1;
            mul_cnt_reg <= mul_cnt_reg + 1'b1;
          end
        end
`endif
        default: begin
          // DONE: one-cycle pulse, then back to IDLE; start here is ignored.
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_reg;
  assign bus.done   = done_reg;
  assign bus.result = result_reg;
  assign bus.flags  = flags_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq. Checks reset state, every opcode with
// hand-computed results/flags, latency, busy length, start-while-busy,
// reset mid-operation and reset/start collision. Builds with or without
// ALU_MUL_EN.
module tb_alu_seq;

  localparam int WIDTH = 16;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  alu_seq_if #(.WIDTH(WIDTH)) bus_if ();

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents one request, then watches 40 cycles. Latency is counted in
  // cycles from the cycle start is presented. extra_at>0 pulses a stray
  // start (with other operands) for one cycle at that cycle index.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [15:0] x,
                        input logic [15:0] y, input logic [15:0] exp_res,
                        input logic [3:0] exp_flags, input int exp_lat, input int extra_at);
    int done_lat;
    int done_cnt;
    int busy_cnt;
    logic [15:0] res_at_done;
    logic [3:0]  flg_at_done;
    done_lat = 0;
    done_cnt = 0;
    busy_cnt = 0;
    res_at_done = '0;
    flg_at_done = '0;
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.op    = o;
    bus_if.a     = x;
    bus_if.b     = y;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    bus_if.a     = 16'hDEAD;
    bus_if.b     = 16'hBEEF;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (bus_if.busy) busy_cnt++;
      if (bus_if.done) begin
        done_cnt++;
        if (done_lat == 0) begin
          done_lat    = cyc;
          res_at_done = bus_if.result;
          flg_at_done = bus_if.flags;
        end
      end
      if (extra_at > 0 && cyc == extra_at) begin
        bus_if.start = 1'b1;
        bus_if.op    = 3'b000;
        bus_if.a     = 16'h1111;
        bus_if.b     = 16'h2222;
      end else begin
        bus_if.start = 1'b0;
      end
    end
    $display("[TB] %s op=%0d a=0x%04h b=0x%04h -> result=0x%04h flags=%b lat=%0d",
             tag, o, x, y, res_at_done, flg_at_done, done_lat);
    check({tag, ".result"}, 32'(res_at_done), 32'(exp_res));
    check({tag, ".flags"}, 32'(flg_at_done), 32'(exp_flags));
    check({tag, ".latency"}, 32'(done_lat), 32'(exp_lat));
    check({tag, ".done_count"}, 32'(done_cnt), 32'd1);
    check({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
    check({tag, ".result_held"}, 32'(bus_if.result), 32'(exp_res));
    check({tag, ".flags_held"}, 32'(bus_if.flags), 32'(exp_flags));
  endtask

  initial begin
    int busy_seen;
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    bus_if.start = 1'b0;
    bus_if.op    = 3'b000;
    bus_if.a     = '0;
    bus_if.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    $display("[TB] reset state busy=%b done=%b result=0x%04h flags=%b",
             bus_if.busy, bus_if.done, bus_if.result, bus_if.flags);
    check("rst.busy", 32'(bus_if.busy), 32'd0);
    check("rst.done", 32'(bus_if.done), 32'd0);
    check("rst.result", 32'(bus_if.result), 32'd0);
    check("rst.flags", 32'(bus_if.flags), 32'd0);

    // ADD overflow; a stray start during the DONE cycle must be ignored.
    run_op("add_ovf", 3'b000, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 2, 2);
    run_op("add_carry", 3'b000, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010, 2, 0);
    run_op("sub_eq", 3'b001, 16'h0005, 16'h0005, 16'h0000, 4'b1010, 2, 0);
    run_op("sub_borrow", 3'b001, 16'h0000, 16'h0001, 16'hFFFF, 4'b0100, 2, 0);
    run_op("sub_ovf", 3'b001, 16'h8000, 16'h0001, 16'h7FFF, 4'b0011, 2, 0);
    run_op("and", 3'b010, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000, 2, 0);
    run_op("orr", 3'b011, 16'h8000, 16'h0001, 16'h8001, 4'b0100, 2, 0);
    run_op("eor", 3'b100, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b1000, 2, 0);
    run_op("lsl1", 3'b101, 16'h8001, 16'h0001, 16'h0002, 4'b0010, 2, 0);
    run_op("lsl0", 3'b101, 16'h1234, 16'h0000, 16'h1234, 4'b0000, 2, 0);
    run_op("lsl15", 3'b101, 16'h0003, 16'h000F, 16'h8000, 4'b0110, 2, 0);
    run_op("lsr1", 3'b110, 16'h0001, 16'h0001, 16'h0000, 4'b1010, 2, 0);
    run_op("lsr15", 3'b110, 16'h8000, 16'hFFFF, 16'h0001, 4'b0000, 2, 0);
`ifdef ALU_MUL_EN
    run_op("mul_small", 3'b111, 16'h0003, 16'h0004, 16'h000C, 4'b0000, 18, 0);
    // Stray start in the middle of the multiply must not restart or re-latch.
    run_op("mul_hi", 3'b111, 16'h0100, 16'h0100, 16'h0000, 4'b1010, 18, 5);
    run_op("mul_max", 3'b111, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0010, 18, 0);
`else
    run_op("mul_off", 3'b111, 16'h0003, 16'h0004, 16'h0000, 4'b1000, 2, 0);
    run_op("add_nz", 3'b000, 16'h0010, 16'h0001, 16'h0011, 4'b0000, 2, 0);
`endif

    // Reset in the middle of an operation (5th MUL cycle when built, else EXEC).
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.op    = 3'b111;
    bus_if.a     = 16'h0005;
    bus_if.b     = 16'h0007;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
`ifdef ALU_MUL_EN
    repeat (5) @(negedge clk);
`else
    repeat (1) @(negedge clk);
`endif
    check("midrst.busy_before", 32'(bus_if.busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    $display("[TB] mid-op reset busy=%b done=%b result=0x%04h flags=%b",
             bus_if.busy, bus_if.done, bus_if.result, bus_if.flags);
    check("midrst.busy", 32'(bus_if.busy), 32'd0);
    check("midrst.done", 32'(bus_if.done), 32'd0);
    check("midrst.result", 32'(bus_if.result), 32'd0);
    check("midrst.flags", 32'(bus_if.flags), 32'd0);
    reset = 1'b0;
    run_op("add_after_rst", 3'b000, 16'h0002, 16'h0003, 16'h0005, 4'b0000, 2, 0);

    // start coincident with reset must be discarded.
    @(negedge clk);
    reset        = 1'b1;
    bus_if.start = 1'b1;
    bus_if.op    = 3'b000;
    bus_if.a     = 16'h0001;
    bus_if.b     = 16'h0001;
    @(posedge clk);
    #1;
    reset        = 1'b0;
    bus_if.start = 1'b0;
    busy_seen    = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus_if.busy || bus_if.done) busy_seen++;
    end
    $display("[TB] reset+start collision busy/done cycles=%0d result=0x%04h",
             busy_seen, bus_if.result);
    check("rst_start.activity", 32'(busy_seen), 32'd0);
    check("rst_start.result", 32'(bus_if.result), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
